// File: rtl/store_merge_buffer.sv
// Single-line write-merge buffer between the LC-3b store port and the L1 data array.
// Stores merge into a held 128-bit line image; the line drains on a line change or flush.
module store_merge_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         st_valid,
  input  logic [15:0]  st_addr,
  input  logic [15:0]  st_wdata,
  input  logic [1:0]   st_be,
  output logic         st_ready,
  input  logic         flush,
  output logic         empty,
  output logic         wb_req,
  output logic [15:0]  wb_addr,
  output logic [127:0] wb_line,
  output logic [15:0]  wb_mask,
  input  logic         wb_ack,
  input  logic [15:0]  ld_addr,
  output logic [15:0]  ld_data,
  output logic [1:0]   ld_bytes,
  output logic [1:0]   dbg_state
);

  // Store handshake: a store transfers on a rising edge where st_valid && st_ready.
  // st_ready does not depend on st_valid; a store refused on a line change must be held
  // by the producer until the drain completes. Write-back transfers on wb_req && wb_ack.

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  logic [11:0]    tag_q;
  logic [127:0]   line_q;
  logic [15:0]    mask_q;

  logic [127:0]   line_d;
  logic [15:0]    mask_d;

  logic [2:0]     st_off;
  logic [11:0]    st_line;
  logic           st_hit;
  logic           st_live;
  logic [6:0]     st_bit;
  logic [3:0]     st_byte;

  logic [2:0]     ld_off;
  logic           ld_hit;

  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^{st_addr[0], ld_addr[0]};

  assign st_off  = st_addr[3:1];
  assign st_line = st_addr[15:4];
  assign st_hit  = (st_line == tag_q);
  assign st_live = st_valid && (st_be != 2'b00);
  assign st_bit  = {st_off, 4'b0000};
  assign st_byte = {st_off, 1'b0};

  // Merge image: an EMPTY buffer starts from a zeroed line so unmasked bytes stay 0.
  always_comb begin
    line_d = (state_q == S_EMPTY) ? '0 : line_q;
    mask_d = (state_q == S_EMPTY) ? '0 : mask_q;
    if (st_be[0]) begin
      line_d[st_bit +: 8] = st_wdata[7:0];
      mask_d[st_byte]     = 1'b1;
    end
    if (st_be[1]) begin
      line_d[(st_bit + 7'd8) +: 8] = st_wdata[15:8];
      mask_d[st_byte + 4'd1]       = 1'b1;
    end
  end

  always_comb begin
    st_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        S_EMPTY: st_ready = 1'b1;
        S_HOLD:  st_ready = (st_be == 2'b00) || (!flush && st_hit);
        default: st_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      tag_q   <= '0;
      line_q  <= '0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (st_live) begin
            tag_q   <= st_line;
            line_q  <= line_d;
            mask_q  <= mask_d;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          // flush wins over a same-line store arriving in the same cycle
          if (flush) begin
            state_q <= S_DRAIN;
          end else if (st_live) begin
            if (st_hit) begin
              line_q <= line_d;
              mask_q <= mask_d;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (wb_ack) begin
            line_q  <= '0;
            mask_q  <= '0;
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign empty     = (state_q == S_EMPTY);
  assign wb_req    = (state_q == S_DRAIN);
  assign wb_addr   = {tag_q, 4'b0000};
  assign wb_line   = line_q;
  assign wb_mask   = mask_q;
  assign dbg_state = state_q;

  assign ld_off   = ld_addr[3:1];
  assign ld_hit   = (state_q != S_EMPTY) && (ld_addr[15:4] == tag_q);
  assign ld_data  = line_q[{ld_off, 4'b0000} +: 16];
  assign ld_bytes = ld_hit ? mask_q[{ld_off, 1'b0} +: 2] : 2'b00;

endmodule

// File: tb/tb_store_merge_buffer.sv
// Bench for store_merge_buffer: directed scenarios plus random stores/flushes,
// with expected write-backs queued by a byte-array model and checked by a monitor.
module tb_store_merge_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         st_valid;
  logic [15:0]  st_addr;
  logic [15:0]  st_wdata;
  logic [1:0]   st_be;
  logic         st_ready;
  logic         flush;
  logic         empty;
  logic         wb_req;
  logic [15:0]  wb_addr;
  logic [127:0] wb_line;
  logic [15:0]  wb_mask;
  logic         wb_ack = 1'b0;
  logic [15:0]  ld_addr;
  logic [15:0]  ld_data;
  logic [1:0]   ld_bytes;
  logic [1:0]   dbg_state;

  store_merge_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
    .st_ready(st_ready), .flush(flush), .empty(empty),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line), .wb_mask(wb_mask),
    .wb_ack(wb_ack), .ld_addr(ld_addr), .ld_data(ld_data), .ld_bytes(ld_bytes),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [159:0] exp_q[$];   // {wb_addr, wb_line, wb_mask}
  bit ack_en = 1'b1;

  // Reference model: the held line as 16 bytes plus a valid mask.
  logic [7:0]  m_b[16];
  logic [15:0] m_mask;
  logic [11:0] m_tag;
  bit          m_held;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_line();
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = m_b[k];
    return l;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_b[k] = 8'h00;
    m_mask = 16'h0000;
    m_held = 1'b0;
  endtask

  task automatic model_push();
    exp_q.push_back({m_tag, 4'b0000, m_line(), m_mask});
    model_clear();
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    int cnt;
    int o;
    int lo;
    cnt = 0;
    if (be != 2'b00 && m_held && a[15:4] != m_tag) model_push();
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_be = be;
    #1;
    while (!st_ready && cnt < 100) begin
      @(negedge clk); #1; cnt++;
    end
    if (!st_ready) begin
      check("store_accept_timeout", 1'b0, 1'b1);
      st_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    if (be != 2'b00) begin
      if (!m_held) begin
        m_tag = a[15:4];
        m_held = 1'b1;
      end
      o = int'(a[3:1]);
      if (be[0]) begin m_b[2*o] = d[7:0];    m_mask[2*o] = 1'b1;   end
      if (be[1]) begin m_b[2*o+1] = d[15:8]; m_mask[2*o+1] = 1'b1; end
      lo = $urandom_range(0, 7);
      ld_addr = {m_tag, lo[2:0], 1'b0};
      #1;
      check("fwd_data", ld_data, {m_b[2*lo+1], m_b[2*lo]});
      check("fwd_bytes", ld_bytes, {m_mask[2*lo+1], m_mask[2*lo]});
      ld_addr = {m_tag + 12'd1, lo[2:0], 1'b1};
      #1;
      check("fwd_miss_bytes", ld_bytes, 2'b00);
    end
  endtask

  task automatic do_flush();
    if (m_held) model_push();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic flush_with_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    if (m_held) model_push();
    @(negedge clk);
    flush = 1'b1;
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_be = be;
    #1;
    check("flush_store_ready", st_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    st_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk); cnt++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: acks write-backs at random and compares each against the queue head.
  logic [15:0]  prev_addr;
  logic [127:0] prev_line;
  logic [15:0]  prev_mask;
  bit           prev_req = 1'b0;

  always @(negedge clk) begin
    logic [159:0] e;
    if (wb_req && !reset) begin
      if (prev_req) begin
        check("wb_addr_stable", wb_addr, prev_addr);
        check("wb_line_stable", wb_line, prev_line);
        check("wb_mask_stable", wb_mask, prev_mask);
      end
      prev_req = 1'b1;
      prev_addr = wb_addr; prev_line = wb_line; prev_mask = wb_mask;
      if (ack_en && $urandom_range(0, 2) != 0) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", wb_addr, e[159:144]);
          check("wb_line", wb_line, e[143:16]);
          check("wb_mask", wb_mask, e[15:0]);
        end
        wb_ack = 1'b1;
        prev_req = 1'b0;
      end else begin
        wb_ack = 1'b0;
      end
    end else begin
      wb_ack = 1'b0;
      prev_req = 1'b0;
    end
  end

  initial begin
    logic [127:0] saved;
    logic [11:0]  tag;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    flush = 1'b0; ld_addr = '0;
    model_clear();
    m_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_st_ready", st_ready, 1'b0);
    check("rst_wb_req", wb_req, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_ld_bytes", ld_bytes, 2'b00);
    check("rst_wb_mask", wb_mask, 16'h0000);
    check("rst_wb_line", wb_line, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word store then flush
    do_store(16'h1234, 16'hBEEF, 2'b11);
    ack_en = 1'b0;
    do_flush();
    @(negedge clk);
    check("t1_wb_req", wb_req, 1'b1);
    check("t1_wb_addr", wb_addr, 16'h1230);
    check("t1_wb_line", wb_line, 128'h0000_0000_0000_0000_0000_BEEF_0000_0000);
    check("t1_wb_mask", wb_mask, 16'h0030);
    ack_en = 1'b1;
    wait_drained();

    // Two byte stores merge into one word
    do_store(16'h1230, 16'h00AA, 2'b01);
    do_store(16'h1231, 16'hBB00, 2'b10);
    ack_en = 1'b0;
    do_flush();
    @(negedge clk);
    check("t2_wb_word0", {112'h0, wb_line[15:0]}, 128'hBBAA);
    check("t2_wb_mask", wb_mask, 16'h0003);
    ack_en = 1'b1;
    wait_drained();

    // Line conflict with delayed ack
    do_store(16'h1230, 16'h1111, 2'b11);
    ack_en = 1'b0;
    fork
      do_store(16'h2002, 16'hCAFE, 2'b11);
      begin
        @(negedge clk); #2;
        check("t3_conflict_ready", st_ready, 1'b0);
        @(negedge clk); #2;
        check("t3_wb_req", wb_req, 1'b1);
        check("t3_wb_addr", wb_addr, 16'h1230);
        saved = wb_line;
        repeat (3) begin
          @(negedge clk); #2;
          check("t3_wb_req_held", wb_req, 1'b1);
          check("t3_wb_line_held", wb_line, saved);
        end
        ack_en = 1'b1;
      end
    join
    ack_en = 1'b0;
    do_flush();
    @(negedge clk);
    check("t3_wb_addr2", wb_addr, 16'h2000);
    check("t3_wb_mask2", wb_mask, 16'h000C);
    ack_en = 1'b1;
    wait_drained();

    // Load forwarding of a single held byte
    do_store(16'h1232, 16'h0077, 2'b01);
    ld_addr = 16'h1232; #1;
    check("t4_ld_bytes", ld_bytes, 2'b01);
    check("t4_ld_low", {8'h00, ld_data[7:0]}, 16'h0077);
    ld_addr = 16'h1242; #1;
    check("t4_ld_miss", ld_bytes, 2'b00);
    do_flush();
    wait_drained();

    // Flush beats a same-line store
    do_store(16'h1230, 16'h0102, 2'b11);
    flush_with_store(16'h1234, 16'h5555, 2'b11);
    wait_drained();

    // Reset during drain discards the line
    do_store(16'h1240, 16'hABCD, 2'b11);
    ack_en = 1'b0;
    do_flush();
    @(negedge clk);
    check("t6_wb_req", wb_req, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_wb_req_rst", wb_req, 1'b0);
    check("t6_empty_rst", empty, 1'b1);
    check("t6_mask_rst", wb_mask, 16'h0000);
    check("t6_ready_rst", st_ready, 1'b0);
    void'(exp_q.pop_back());
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;

    // Random stores and flushes over a few lines
    repeat (300) begin
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 2))
          0:       tag = 12'h123;
          1:       tag = 12'h124;
          default: tag = 12'h3A0;
        endcase
        do_store({tag, 4'($urandom_range(0, 15))}, 16'($urandom), 2'($urandom_range(0, 3)));
      end else begin
        do_flush();
      end
    end
    do_flush();
    wait_drained();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_merge_buffer.md
# store_merge_buffer

Single-line write-merge buffer between the LC-3b datapath store port and the L1 cache data array. It places 16-bit stores (whole word or single byte) into a 128-bit line image at the selected word offset and tracks a per-byte valid mask. It writes the merged line back through a req/ack handshake when a store targets a different line or on flush. It also forwards held bytes to loads.

## Interface
- Parameters: none; widths come from lc3b_types (lc3b_word 16, lc3b_cache_offset 3, lc3b_cache_size 128).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request.
- st_addr  in  16  byte address; line = st_addr[15:4], word offset = st_addr[3:1], st_addr[0] ignored.
- st_wdata  in  16  store data, already lane-aligned (low byte in [7:0], high byte in [15:8]).
- st_be  in  2  byte enables; [0] low byte, [1] high byte.
- st_ready  out  1  store accepted this cycle when st_valid && st_ready.
- flush  in  1  level request to drain the held line.
- empty  out  1  no line held (state EMPTY).
- wb_req  out  1  write-back request.
- wb_addr  out  16  line-aligned address {line, 4'b0}.
- wb_line  out  128  merged line; byte k = bits [8k+7:8k]; unmasked bytes are 0.
- wb_mask  out  16  byte valid mask; bit k covers byte k.
- wb_ack  in  1  write-back complete; sampled only while wb_req=1.
- ld_addr  in  16  load probe address.
- ld_data  out  16  held word at ld_addr[3:1] (combinational).
- ld_bytes  out  2  per-byte hit: mask bits {2o+1, 2o} of the held line when the line matches and the state is not EMPTY, else 00.

## Operation
- States: EMPTY, HOLD, DRAIN. Registers: state, line_tag[11:0], line[127:0], mask[15:0].
- Byte mapping for offset o: st_be[0] writes byte 2o (bits 16o+7:16o), and st_be[1] writes byte 2o+1. Each written byte sets its mask bit. Unwritten bytes keep their value.
- A store with st_be=00 is always accepted as a no-op (st_ready=1 in EMPTY and HOLD) and causes no state change.
- EMPTY:
  - st_ready=1.
  - An accepted store with nonzero st_be loads line_tag, writes its bytes into a zeroed line, sets its mask bits, and moves to HOLD.
  - flush is ignored.
- HOLD:
  - st_ready = !flush && (st_addr[15:4]==line_tag), or st_be=00.
  - An accepted same-line store merges. A later store to the same byte overwrites it.
  - A pending nonzero store to a different line gives st_ready=0 and moves to DRAIN; the producer holds the store.
  - flush=1 moves to DRAIN. A same-line store in the same cycle is not accepted.
- DRAIN:
  - st_ready=0 and wb_req=1.
  - wb_addr, wb_line and wb_mask are stable until ack.
  - wb_ack=1 moves to EMPTY and clears line and mask to 0.
- Load forwarding: ld_data = line[16o+15:16o] with o = ld_addr[3:1]. ld_bytes is valid in HOLD and DRAIN.

## Timing
- Reset values: state EMPTY, line 0, mask 0, line_tag 0; wb_req=0, empty=1, ld_bytes=00. st_ready=0 while reset=1.
- Store merge is visible on ld_data, ld_bytes and wb_line one cycle after acceptance.
- A conflict or flush detected in cycle N gives wb_req=1 from N+1.
- wb_ack in cycle M gives EMPTY in M+1, where a new store is accepted. Minimum conflict turnaround is 2 cycles (ack allowed in the first DRAIN cycle).
- wb_req, wb_addr and wb_line are registered state. No combinational path from wb_ack to wb_req.
- reset has priority over every event, including in DRAIN: wb_req drops in the next cycle and the held data is discarded.

## Test plan
- Reset, then store 0x1234 / 0xBEEF / be=11, then flush → wb_req=1 one cycle later. Required: wb_addr=0x1230, wb_line[47:32]=0xBEEF, all other bytes 0, wb_mask=0x0030.
- Store 0x1230 / 0x00AA / be=01, then 0x1231 / 0xBB00 / be=10, then flush → wb_line[15:0]=0xBBAA, wb_mask=0x0003.
- HOLD line 0x1230, then store 0x2002 be=11 → st_ready=0, wb_req next cycle. Hold wb_ack=0 for 3 cycles → outputs stable. Ack → EMPTY. The store is then accepted, and a later flush gives wb_addr=0x2000, wb_mask=0x000C.
- HOLD with byte 2 only (store 0x1232 / 0x0077 / be=01) → ld_addr=0x1232 gives ld_bytes=01 and ld_data[7:0]=0x77. ld_addr=0x1242 gives ld_bytes=00.
- HOLD, then flush=1 together with a same-line store in one cycle → st_ready=0, DRAIN, and wb_line excludes that store.
- Reset asserted in DRAIN with wb_ack=0 → next cycle wb_req=0, empty=1, wb_mask=0.
